// File: rtl/sdp_debounce_if.sv
// Register access bus for sdp_debounce: write port (W1C event clear) and registered read port.
interface sdp_debounce_if #(
    parameter int unsigned WIDTH = 1
);
    logic             wa;
    logic             we;
    logic [WIDTH-1:0] wd;
    logic             ra;
    logic             re;
    logic [WIDTH-1:0] rd;

    modport master (output wa, we, wd, ra, re, input rd);
    modport slave  (input wa, we, wd, ra, re, output rd);
endinterface

// File: rtl/sdp_debounce.sv
// Per-bit synchronizer + debounce filter with edge pulses, sticky event register and irq.
module sdp_debounce #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STABLE = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] db_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             irq_o,
    sdp_debounce_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

    logic [WIDTH-1:0] sync0_q, sync1_q;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] evt_q, evt_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] clr;

    // Qualification: a differing level must persist STABLE edges; any agreement restarts the count.
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync1_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]  = '0;
                db_d[i]   = sync1_q[i];
                rise_d[i] = sync1_q[i];
                fall_d[i] = ~sync1_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Sticky events from the registered pulses; a coincident set beats the W1C clear.
    always_comb begin
        clr   = (bus.we && bus.wa) ? bus.wd : '0;
        evt_d = (evt_q & ~clr) | rise_q | fall_q;
        irq_d = |evt_d;
        rd_d  = rd_q;
        if (bus.re) begin
            rd_d = bus.ra ? evt_q : db_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            evt_q   <= '0;
            rd_q    <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync0_q <= pin_i;
            sync1_q <= sync0_q;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
            rd_q    <= rd_d;
            irq_q   <= irq_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign irq_o  = irq_q;
    assign bus.rd = rd_q;
endmodule

// File: doc/sdp_debounce.md
SDP_DEBOUNCE -- requirements
Module: sdp_debounce

Interface
REQ-001: Parameter WIDTH, default 1: number of independent input channels.
REQ-002: Parameter STABLE, default 1000: number of consecutive cycles a new synchronized level must hold before it is accepted; legal range is STABLE >= 1.
REQ-003: clk  input  1  clock; all state SHALL be updated on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: pin_i  input  WIDTH  raw asynchronous inputs (buttons, switches).
REQ-006: db_o  output  WIDTH  debounced levels; this output feeds the gpio_i input of the sdp_gpio stage.
REQ-007: rise_o  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
REQ-008: fall_o  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
REQ-009: wa  input  1  write address: 0 = level register (read-only), 1 = event register.
REQ-010: we  input  1  write enable.
REQ-011: wd  input  WIDTH  write data.
REQ-012: ra  input  1  read address, using the same map as wa.
REQ-013: re  input  1  read enable.
REQ-014: rd  output  WIDTH  registered read data.
REQ-015: irq_o  output  1  OR-reduction of the event register.

Function
REQ-016: Each pin_i bit SHALL pass through a 2-flop synchronizer (sync0 -> sync1); only sync1 feeds the debounce logic.
REQ-017: Each bit SHALL own a counter of width $clog2(STABLE+1); the counter SHALL saturate at STABLE-1 and never wrap.
REQ-018: If sync1 == db, the counter SHALL be cleared to 0 on the same edge.
REQ-019: If sync1 != db and the counter < STABLE-1, the counter SHALL increment.
REQ-020: If sync1 != db and the counter == STABLE-1, then on that edge db <= sync1, the counter <= 0, and the matching rise/fall bit SHALL be 1 for exactly that cycle.
REQ-021: Latency: a level first captured by sync0 at edge k and held SHALL appear on db_o after edge k+1+STABLE; any glitch shorter than STABLE cycles at sync1 SHALL produce no db_o change and no pulse.
REQ-022: A bounce that returns sync1 to db at any point SHALL restart qualification from 0.
REQ-023: rise_o and fall_o SHALL be registered and SHALL never be 1 simultaneously for the same bit; bits SHALL be fully independent.
REQ-024: The event register evt[i] SHALL be set by rise_o[i] | fall_o[i] (sticky).
REQ-025: A write with we && wa==1 SHALL clear each evt bit where wd is 1 (write-1-to-clear).
REQ-026: If a set and a clear coincide on the same bit, the set SHALL win.
REQ-027: A write with we && wa==0 SHALL be ignored.
REQ-028: On re, rd SHALL load on the next edge: db when ra==0, evt when ra==1.
REQ-029: When re==0, rd SHALL hold its value.
REQ-030: A read of evt coincident with a W1C SHALL return the pre-clear value.
REQ-031: irq_o SHALL be |evt, driven from flops with no combinational path from pin_i.

Reset
REQ-032: On rst_n low, the following SHALL clear to 0 immediately and asynchronously: sync0, sync1, db, all counters, rise_o, fall_o, evt, and rd; irq_o SHALL therefore be 0.
REQ-033: Reset asserted mid-qualification SHALL discard the partial count.
REQ-034: After release, an input held at 1 SHALL produce a normal qualified rise (event set) after 2+STABLE cycles.

Verification (WIDTH=2, STABLE=4)
REQ-035: Scenario: pin_i 00->01 held -> db_o==01 at the 6th edge after the change, rise_o==01 for one cycle, evt==01, irq_o==1.
REQ-036: Scenario: pin_i[0] pulses high for 3 cycles -> db_o stays 00, no pulses, evt==00.
REQ-037: Scenario: bounce pattern 1,1,1,0,1,1,1,1 on bit 1 -> single rise, accepted 4 cycles after the last 0, exactly one rise_o pulse.
REQ-038: Scenario: evt==11, we=1 wa=1 wd=01 -> evt==10; the same write in the cycle bit 0 gets a new fall -> evt[0] stays 1.
REQ-039: Scenario: re=1 ra=0 then ra=1 -> rd shows db then evt one edge later; with re=0, rd holds.
REQ-040: Scenario: rst_n pulsed low during a count of 3 -> all outputs 0 immediately; with pin held at 1 after release, the rise occurs 6 edges later.
